// File: rtl/axi_pkg.sv
// Shared AXI definitions for the on-chip RAM slave: burst and response
// encodings, the write/read FSM state types, and a helper that says
// whether this slave can execute a given burst type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

  // WRAP and the reserved encoding get SLVERR and never touch the RAM.
  function automatic logic burst_ok(input logic [1:0] b);
    return (b == BURST_FIXED) || (b == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_slave_ram_if.sv
// AXI4 full bus bundle between a master and axi_slave_ram.
// Groups the five channels (AW, W, B, AR, R); the slave modport is
// used by the RAM, the master modport by whatever drives it.
interface axi_slave_ram_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_slave_ram_sdp_ram_be.sv
// sdp_ram_be: simple dual-port RAM, one byte-enabled write port and one
// synchronous read port on the same clock. Read-first: a read and write
// to the same word in one cycle returns the old contents.
// Ports: clk; we_i (byte enables), waddr_i, wdata_i; re_i, raddr_i,
// rdata_o (valid the cycle after re_i). Contents are not reset.
module sdp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
)(
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (we_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 full slave backed by a word-addressed on-chip RAM.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs,
// one outstanding transaction each, sharing an sdp_ram_be.
// Ports: clk, rst (async, active-low), s_axi (slave modport of the bus).
// Read path: the RAM is prefetched into a 2-entry skid FIFO with a
// bypass, so the first beat shows 2 cycles after AR and a held rready
// streams one beat per cycle.
module axi_slave_ram
  import axi_pkg::*;
#(
  parameter int S_AXI_ID_WIDTH   = 1,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2   = 10,
  parameter logic [S_AXI_ADDR_WIDTH-1:0] S_BASE_ADDR = 'h4000_0000
)(
  input logic             clk,
  input logic             rst,
  axi_slave_ram_if.slave  s_axi
);
  localparam int STRB_W   = S_AXI_DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(STRB_W);

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

  // Byte offset from the base; index bits above the depth alias.
  logic [S_AXI_ADDR_WIDTH-1:0] aw_off, ar_off;
  assign aw_off = s_axi.awaddr - S_BASE_ADDR;
  assign ar_off = s_axi.araddr - S_BASE_ADDR;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awsize, s_axi.arsize, aw_off, ar_off};

  // ---------------- write channel ----------------
  wr_state_e                 w_state_q, w_state_d;
  logic [S_AXI_ID_WIDTH-1:0] wid_q, wid_d;
  idx_t                      widx_q, widx_d;
  logic [7:0]                wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]                wburst_q, wburst_d;
  logic                      werr_q, werr_d;
  logic                      aw_rdy, w_rdy, b_vld;
  logic [STRB_W-1:0]         ram_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wburst_q  <= BURST_FIXED;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wburst_d  = wburst_q;
    werr_d    = werr_q;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    b_vld     = 1'b0;
    ram_we    = '0;
    case (w_state_q)
      W_IDLE: begin
        aw_rdy = 1'b1;
        if (s_axi.awvalid) begin
          wid_d     = s_axi.awid;
          widx_d    = aw_off[ADDR_LSB +: MEM_DEPTH_LOG2];
          wlen_d    = s_axi.awlen;
          wburst_d  = s_axi.awburst;
          wcnt_d    = '0;
          werr_d    = !burst_ok(s_axi.awburst);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (s_axi.wvalid) begin
          if (burst_ok(wburst_q)) ram_we = s_axi.wstrb;
          // The beat count ends the burst; wlast is only cross-checked.
          if (s_axi.wlast != (wcnt_q == wlen_q)) werr_d = 1'b1;
          wcnt_d = wcnt_q + 8'd1;
          if (wburst_q == BURST_INCR) widx_d = widx_q + idx_t'(1);
          if (wcnt_q == wlen_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = b_vld;
  assign s_axi.bid     = wid_q;
  assign s_axi.bresp   = (b_vld && werr_q) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  rd_state_e                 r_state_q, r_state_d;
  logic [S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  idx_t                      ridx_q, ridx_d;
  logic [7:0]                rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]                rburst_q, rburst_d;
  logic                      rdone_q, rdone_d;   // all beats issued to RAM
  logic                      ar_rdy;

  // p1: a RAM read issued last cycle, its data is on ram_rdata now.
  logic                        p1_q, p1_last_q;
  logic [1:0]                  fcnt_q;
  logic                        fwp_q, frp_q;
  logic [1:0]                  flast_q;
  logic [S_AXI_DATA_WIDTH-1:0] fdata_q [2];
  logic [S_AXI_DATA_WIDTH-1:0] ram_rdata, head_data;
  logic                        head_last, fifo_ne, r_vld, pop, fifo_pop, push, issue, rerr;
  logic [2:0]                  occ;

  assign rerr      = !burst_ok(rburst_q);
  assign fifo_ne   = (fcnt_q != 2'd0);
  assign head_data = fifo_ne ? fdata_q[frp_q] : ram_rdata;
  assign head_last = fifo_ne ? flast_q[frp_q] : p1_last_q;
  assign r_vld     = fifo_ne || p1_q;
  assign pop       = r_vld && s_axi.rready;
  assign fifo_pop  = pop && fifo_ne;
  // RAM data bypasses the FIFO only when it is consumed in the same cycle.
  assign push      = p1_q && !(!fifo_ne && pop);
  // Words held after this cycle; issue only if a new one still fits.
  assign occ       = {1'b0, fcnt_q} + {2'b00, p1_q} - {2'b00, pop};
  assign issue     = (r_state_q == R_DATA) && !rdone_q && (occ <= 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rburst_q  <= BURST_FIXED;
      rdone_q   <= 1'b0;
      p1_q      <= 1'b0;
      p1_last_q <= 1'b0;
      fcnt_q    <= '0;
      fwp_q     <= 1'b0;
      frp_q     <= 1'b0;
      flast_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rburst_q  <= rburst_d;
      rdone_q   <= rdone_d;
      p1_q      <= issue;
      p1_last_q <= issue && (rcnt_q == rlen_q);
      fcnt_q    <= fcnt_q + {1'b0, push} - {1'b0, fifo_pop};
      if (push) begin
        flast_q[fwp_q] <= p1_last_q;
        fwp_q          <= ~fwp_q;
      end
      if (fifo_pop) frp_q <= ~frp_q;
    end
  end

  always_ff @(posedge clk)
    if (push) fdata_q[fwp_q] <= ram_rdata;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rburst_d  = rburst_q;
    rdone_d   = rdone_q;
    ar_rdy    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_rdy = 1'b1;
        if (s_axi.arvalid) begin
          rid_d     = s_axi.arid;
          ridx_d    = ar_off[ADDR_LSB +: MEM_DEPTH_LOG2];
          rlen_d    = s_axi.arlen;
          rburst_d  = s_axi.arburst;
          rcnt_d    = '0;
          rdone_d   = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (issue) begin
          if (rcnt_q == rlen_q) rdone_d = 1'b1;
          else                  rcnt_d  = rcnt_q + 8'd1;
          if (rburst_q == BURST_INCR) ridx_d = ridx_q + idx_t'(1);
        end
        if (pop && head_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign s_axi.arready = ar_rdy;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rid     = rid_q;
  assign s_axi.rlast   = r_vld && head_last;
  assign s_axi.rdata   = (r_vld && !rerr) ? head_data : '0;
  assign s_axi.rresp   = (r_vld && rerr) ? RESP_SLVERR : RESP_OKAY;

  sdp_ram_be #(
    .DATA_WIDTH (S_AXI_DATA_WIDTH),
    .ADDR_WIDTH (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (widx_q),
    .wdata_i (s_axi.wdata),
    .re_i    (issue),
    .raddr_i (ridx_q),
    .rdata_o (ram_rdata)
  );
endmodule

// File: tb/tb_axi_slave_ram.sv
// Bench for axi_slave_ram: scenario tasks drive the bus; a memory model
// plus an expected-beat queue supply every expected value.
module tb_axi_slave_ram;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] d; logic [1:0] r; logic l; } beat_t;
  beat_t exp_q[$];
  logic [31:0] mdl [0:1023];

  axi_slave_ram_if #(.ID_W(1), .ADDR_W(32), .DATA_W(32)) bus();

  axi_slave_ram #(
    .S_AXI_ID_WIDTH(1), .S_AXI_ADDR_WIDTH(32), .S_AXI_DATA_WIDTH(32),
    .MEM_DEPTH_LOG2(10), .S_BASE_ADDR(32'h4000_0000)
  ) dut (.clk(clk), .rst(rst), .s_axi(bus));

  always #5 clk = ~clk;

  function automatic int aidx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - 32'h4000_0000) >> 2;
    return int'(o[9:0]);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [31:0] base, input logic [3:0] strb, input int bad_last,
                          input logic [1:0] exp_resp, input logic id, input string nm);
    int n, beats, idx;
    logic [31:0] d;
    idx = aidx(addr);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
    bus.awsize = 3'd2; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    beats = 0;
    for (int i = 0; i <= int'(len); i++) begin
      d = base + i;
      bus.wdata = d; bus.wstrb = strb; bus.wvalid = 1'b1;
      bus.wlast = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      n = 0;
      while (!bus.wready && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.wready) break;
      @(posedge clk); #1;
      beats++;
      if (burst == 2'b00 || burst == 2'b01) begin
        for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
        if (burst == 2'b01) idx = (idx + 1) % 1024;
      end
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    checks++;
    if (beats != int'(len) + 1 || bus.wready !== 1'b0) begin
      failures++;
      $display("FAIL %s w_beats: got %0d wready=%b, want %0d wready=0", nm, beats, bus.wready, int'(len) + 1);
    end
    n = 0;
    while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp) begin
      failures++;
      $display("FAIL %s bresp: got bvalid=%b bresp=%b, want 1/%b", nm, bus.bvalid, bus.bresp, exp_resp);
    end
    checks++;
    if (bus.bid !== id) begin
      failures++;
      $display("FAIL %s bid: got %b want %b", nm, bus.bid, id);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
      failures++;
      $display("FAIL %s b_done: got bvalid=%b awready=%b, want 0/1", nm, bus.bvalid, bus.awready);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic id, input bit toggle, input int abort_beat, input string nm);
    int n, cyc, beats, first, idx;
    bit stalled;
    logic [31:0] hold;
    beat_t e;
    idx = aidx(addr);
    for (int i = 0; i <= int'(len); i++) begin
      e.l = (i == int'(len));
      if (burst == 2'b00 || burst == 2'b01) begin e.d = mdl[idx]; e.r = 2'b00; end
      else begin e.d = 32'h0; e.r = 2'b10; end
      exp_q.push_back(e);
      if (burst == 2'b01) idx = (idx + 1) % 1024;
    end
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
    bus.arsize = 3'd2; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    cyc = 1; beats = 0; first = -1; stalled = 0; hold = '0;
    while (beats <= int'(len) && cyc < 400) begin
      bus.rready = !toggle || (cyc % 2 == 1);
      if (bus.rvalid) begin
        if (first < 0) begin
          first = cyc;
          checks++;
          if (first != 2) begin
            failures++;
            $display("FAIL %s latency: first rvalid at cycle %0d, want 2", nm, first);
          end
        end
        if (stalled) begin
          checks++;
          if (bus.rdata !== hold) begin
            failures++;
            $display("FAIL %s stall_hold: got %h want %h", nm, bus.rdata, hold);
          end
        end
        if (beats == abort_beat) begin
          rst = 1'b0;
          #1;
          checks++;
          if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1 || bus.rlast !== 1'b0 || bus.rid !== 1'b0) begin
            failures++;
            $display("FAIL %s mid_reset: got rvalid=%b arready=%b rlast=%b rid=%b, want 0/1/0/0",
                     nm, bus.rvalid, bus.arready, bus.rlast, bus.rid);
          end
          bus.rready = 1'b0;
          exp_q.delete();
          @(posedge clk); #1;
          rst = 1'b1;
          @(posedge clk); #1;
          return;
        end
        if (bus.rready) begin
          e = exp_q.pop_front();
          checks++;
          if (bus.rdata !== e.d || bus.rresp !== e.r || bus.rlast !== e.l || bus.rid !== id) begin
            failures++;
            $display("FAIL %s beat%0d: got d=%h r=%b l=%b id=%b, want d=%h r=%b l=%b id=%b",
                     nm, beats, bus.rdata, bus.rresp, bus.rlast, bus.rid, e.d, e.r, e.l, id);
          end
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold = bus.rdata;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    checks++;
    if (beats != int'(len) + 1 || bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      failures++;
      $display("FAIL %s r_done: got beats=%0d rvalid=%b arready=%b, want %0d/0/1",
               nm, beats, bus.rvalid, bus.arready, int'(len) + 1);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_ctrl: got aw/ar/w/b/r/last=%b want 110000",
               {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast});
    end
    checks++;
    if (bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.rdata !== 32'h0 || bus.bid !== 1'b0 || bus.rid !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h bid=%b rid=%b, want zeros",
               bus.bresp, bus.rresp, bus.rdata, bus.bid, bus.rid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_incr();
    do_write(32'h4000_0004, 8'd15, 2'b01, 32'h100, 4'hF, -1, 2'b00, 1'b1, "incr_wr");
    do_read (32'h4000_0004, 8'd15, 2'b01, 1'b1, 1'b0, -1, "incr_rd");
  endtask

  task automatic test_rready_toggle();
    do_read(32'h4000_0004, 8'd7, 2'b01, 1'b0, 1'b1, -1, "toggle_rd");
  endtask

  task automatic test_strobe();
    // W presented ahead of AW must stall.
    bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.wready !== 1'b0) begin
        failures++;
        $display("FAIL w_before_aw: got wready=%b want 0", bus.wready);
      end
    end
    bus.wvalid = 1'b0;
    do_write(32'h4000_000C, 8'd0, 2'b01, 32'hAABBCCDD, 4'hF, -1, 2'b00, 1'b0, "strb_wr1");
    do_write(32'h4000_000C, 8'd0, 2'b01, 32'h11223344, 4'h5, -1, 2'b00, 1'b0, "strb_wr2");
    do_read (32'h4000_000C, 8'd0, 2'b01, 1'b0, 1'b0, -1, "strb_rd");
  endtask

  task automatic test_wrap();
    do_write(32'h4000_000C, 8'd3, 2'b10, 32'hDEAD0000, 4'hF, -1, 2'b10, 1'b1, "wrap_wr");
    do_read (32'h4000_000C, 8'd0, 2'b01, 1'b0, 1'b0, -1, "wrap_unchanged");
    do_read (32'h4000_000C, 8'd3, 2'b10, 1'b1, 1'b0, -1, "wrap_rd");
    do_read (32'h4000_000C, 8'd1, 2'b11, 1'b0, 1'b0, -1, "rsvd_rd");
  endtask

  task automatic test_wlast_err();
    do_write(32'h4000_00A0, 8'd3, 2'b01, 32'h200, 4'hF, 2, 2'b10, 1'b1, "wlast_err");
    do_read (32'h4000_00A0, 8'd3, 2'b01, 1'b1, 1'b0, -1, "wlast_rd");
  endtask

  task automatic test_fixed();
    do_write(32'h4000_00C8, 8'd3, 2'b00, 32'h300, 4'hF, -1, 2'b00, 1'b0, "fixed_wr");
    do_read (32'h4000_00C8, 8'd2, 2'b00, 1'b0, 1'b0, -1, "fixed_rd");
  endtask

  task automatic test_simultaneous();
    fork
      do_write(32'h4000_0190, 8'd1, 2'b01, 32'h400, 4'hF, -1, 2'b00, 1'b1, "sim_wr");
      do_read (32'h4000_0004, 8'd3, 2'b01, 1'b0, 1'b0, -1, "sim_rd");
    join
    do_read(32'h4000_0190, 8'd1, 2'b01, 1'b1, 1'b0, -1, "sim_rdback");
  endtask

  task automatic test_reset_mid_read();
    do_read(32'h4000_0004, 8'd15, 2'b01, 1'b1, 1'b0, 5, "rst_rd");
    do_read(32'h4000_0004, 8'd15, 2'b01, 1'b0, 1'b0, -1, "post_rst_rd");
  endtask

  initial begin
    rst = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_incr();
    test_rready_toggle();
    test_strobe();
    test_wrap();
    test_wlast_err();
    test_fixed();
    test_simultaneous();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- AXI4 full slave with a word-addressed on-chip RAM. It is the downstream endpoint for axi_master bursts in the axi_controller test system.
- Write and read channels are served by two independent FSMs, each with one outstanding transaction. Both FSMs share a simple dual-port RAM.
- Gives the master a cycle-accurate, self-checking target. Written data can be read back.

Parameters:
- S_AXI_ID_WIDTH, 1, AXI ID width.
- S_AXI_ADDR_WIDTH, 32, byte address width.
- S_AXI_DATA_WIDTH, 32, data width; legal values 32 or 64.
- MEM_DEPTH_LOG2, 10, log2 of RAM depth in words (1024 words).
- S_BASE_ADDR, 32'h4000_0000, base address subtracted before indexing.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- s_axi_awid  in  ID  write ID
- s_axi_awaddr  in  ADDR  write start byte address
- s_axi_awlen  in  8  beats-1
- s_axi_awsize  in  3  beat size; ignored, full width assumed
- s_axi_awburst  in  2  burst type
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DATA  write data
- s_axi_wstrb  in  DATA/8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid  out  ID  response ID
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_arid  in  ID  read ID
- s_axi_araddr  in  ADDR  read start byte address
- s_axi_arlen  in  8  beats-1
- s_axi_arsize  in  3  ignored
- s_axi_arburst  in  2  burst type
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rid  out  ID  read ID
- s_axi_rdata  out  DATA  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready

Behaviour:
- Reset values:
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - bresp=0, rresp=0, rdata=0, bid=0, rid=0.
  - RAM contents are not reset.
- Word index: ((addr - S_BASE_ADDR) >> log2(DATA/8)), truncated to MEM_DEPTH_LOG2 bits. Out-of-range addresses alias modulo depth; no DECERR.
- Burst handling:
  - FIXED (00): index constant across the burst.
  - INCR (01): index +1 per beat, wrapping modulo depth.
  - WRAP (10) and reserved (11): unsupported. Writes are accepted with no RAM update and bresp=SLVERR (2'b10). Reads return rdata=0 with rresp=SLVERR on every beat.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1, wready=0. On awvalid&&awready, latch id, index, len and burst, clear beat counter, go to W_DATA next cycle. awready=0 outside W_IDLE.
  - W_DATA: wready=1. On each wvalid&&wready, write RAM bytes where wstrb[i]=1 and increment the beat counter.
  - The burst ends on the beat where count==len. The beat count is authoritative, not wlast.
  - If wlast is asserted on a non-final beat, or missing on the final beat, set an error flag; bresp=SLVERR.
  - After the final beat, go to W_RESP: bvalid=1, bid=latched id, bresp=OKAY (00) unless an error was flagged. Hold until bready, then go to W_IDLE with awready=1 in the next cycle.
  - W beats presented before the AW handshake stall; wready stays 0.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On handshake, latch id, index, len and burst.
  - First rvalid appears 2 cycles after the AR handshake cycle: one cycle to issue the RAM address, one for the synchronous RAM read.
  - With rready held high, one beat per cycle with no bubbles. A 2-entry skid buffer holds the prefetched word.
  - rdata, rresp and rlast stay stable while rvalid&&!rready.
  - rlast=1 exactly on beat len. After that handshake, return to R_IDLE; arready=1 in the next cycle.
- Same-cycle write and read to the same index: read-first; the read returns the old data.
- Simultaneous AW and AR: both are accepted; the channels are independent.
- rst asserted mid-burst: all FSMs go to IDLE immediately and the outputs take their reset values. RAM contents are retained. A partially completed write leaves its already-written beats in RAM.

Decomposition:
- Shared package axi_pkg:
  - Burst constants: BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
  - Response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - FSM state typedefs for the write and read FSMs.
- One sub-module: sdp_ram_be. Simple dual-port RAM, one byte-enabled write port, one synchronous read port, read-first, parameters DATA_WIDTH and ADDR_WIDTH.

Test Plan:
- INCR write, awaddr=0x4000_0004, awlen=15, data 0x100+i, wstrb=F -> 16 W handshakes, then bvalid with bresp=00. An INCR read of the same region returns 0x100..0x10F with rlast on beat 15 and first rvalid 2 cycles after the AR handshake.
- Read with rready toggled 1/0 every cycle, arlen=7 -> 8 beats with data correct and in order, rdata stable during stalls, no beat lost or duplicated.
- Write 0xAABBCCDD to index 3, then write 0x11223344 with wstrb=0101 -> a read of index 3 returns 0xAA22CC44.
- awburst=WRAP, awlen=3 -> 4 beats accepted, bresp=10, RAM unchanged. arburst=WRAP -> 4 beats with rdata=0, rresp=10.
- wlast asserted on beat 2 of awlen=3 -> 4 beats are still consumed, bresp=10.
- rst pulsed low during beat 5 of a 16-beat read -> rvalid=0 and arready=1 immediately. A new read completes normally and returns the earlier written data.
